// File: rtl/ir_loader_tx_if.sv
// Instruction loader bus: host/ROM source handshake on one side, the
// instruction word bus toward the decoder plus status on the other.
//   start         : request a new load sequence
//   src_data/valid: next instruction word offered by the source
//   src_ready     : loader accepts src_data this cycle
//   data_out      : instruction word driven toward the decoder
//   data_strobe   : one-cycle pulse on the first cycle a new word is driven
//   busy          : sequence in progress
//   load_finished : every word of the load has been sent (level)
//   line_count    : words completed so far
interface ir_loader_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_valid;
    logic                  src_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_strobe;
    logic                  busy;
    logic                  load_finished;
    logic [7:0]            line_count;

    // Host / environment side
    modport master (
        output start, src_data, src_valid,
        input  src_ready, data_out, data_strobe, busy, load_finished, line_count
    );

    // Loader side
    modport slave (
        input  start, src_data, src_valid,
        output src_ready, data_out, data_strobe, busy, load_finished, line_count
    );
endinterface

// File: rtl/ir_loader_tx.sv
// Instruction loader transmitter: pulls LINES words from a valid/ready
// source and drives each onto data_out for HOLD cycles, so a downstream
// two-stage stability sampler sees every word on two consecutive samples.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : ir_loader_tx_if.slave (start, source handshake, word bus, status)
module ir_loader_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LINES      = 255,
    parameter int unsigned HOLD       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ir_loader_tx_if.slave bus
);

    localparam int unsigned HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned LCW = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SRC = 2'd1,
        ST_HOLD     = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                state;
    logic [HCW-1:0]        hold_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  strobe_q;
    logic                  busy_q;
    logic                  fin_q;
    logic [LCW-1:0]        count_q;
    logic [LCW-1:0]        count_inc;

    assign count_inc = count_q + LCW'(1);

    // Sequencer: one word per WAIT_SRC + HOLD cycles, status registered with state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            strobe_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state   <= ST_WAIT_SRC;
                        count_q <= '0;
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WAIT_SRC: begin
                    // A stalled source simply leaves the previous word on the bus
                    if (bus.src_valid) begin
                        data_q   <= bus.src_data;
                        strobe_q <= 1'b1;
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HCW'(HOLD - 1)) begin
                        count_q <= count_inc;
                        if (count_inc == LCW'(LINES)) begin
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            fin_q  <= 1'b1;
                        end else begin
                            state <= ST_WAIT_SRC;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // src_ready is a pure decode of the registered state
    assign bus.src_ready     = (state == ST_WAIT_SRC);
    assign bus.data_out      = data_q;
    assign bus.data_strobe   = strobe_q;
    assign bus.busy          = busy_q;
    assign bus.load_finished = fin_q;
    assign bus.line_count    = count_q;

endmodule

// File: tb/tb_ir_loader_tx.sv
// Bench for ir_loader_tx: a per-cycle vector table for short sequences,
// then three full loads (clean, stalled/repeated/restarted, reset-aborted)
// checked cycle by cycle against a transfer-edge schedule, plus a
// two-stage stability sampler watching data_out.
module tb_ir_loader_tx;

    localparam int DW  = 8;
    localparam int NL  = 255;
    localparam int HD  = 4;
    localparam int PER = HD + 1;

    logic clk;
    logic rst_n;

    ir_loader_tx_if #(.DATA_WIDTH(DW)) bus ();

    ir_loader_tx #(
        .DATA_WIDTH(DW),
        .LINES     (NL),
        .HOLD      (HD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Decoder-style stability sampler on data_out
    logic [7:0] s1, s2, dec;
    always @(posedge clk) begin
        if (!rst_n) begin
            s1  <= 8'h00;
            s2  <= 8'h00;
            dec <= 8'h00;
        end else begin
            s1 <= bus.data_out;
            s2 <= s1;
            if (s1 == s2) dec <= s1;
        end
    end

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic       ready;
        logic [7:0] dout;
        logic       strobe;
        logic       busy;
        logic       fin;
        logic [7:0] count;
    } vec_t;

    vec_t       vecs[21];
    logic [7:0] words[NL];
    int         tk[NL];
    logic [7:0] dec_hist[4096];

    function automatic vec_t mk(input logic r, input logic s, input logic va, input logic [7:0] d,
                                input logic er, input logic [7:0] ed, input logic es,
                                input logic eb, input logic ef, input logic [7:0] ec);
        vec_t v;
        v.rst_n = r;  v.start = s;   v.valid = va; v.data = d;
        v.ready = er; v.dout = ed;   v.strobe = es;
        v.busy = eb;  v.fin = ef;    v.count = ec;
        return v;
    endfunction

    task automatic check(input string name, input int t, input logic er, input logic [7:0] ed,
                         input logic es, input logic eb, input logic ef, input logic [7:0] ec);
        nvec++;
        if ({bus.src_ready, bus.data_out, bus.data_strobe, bus.busy, bus.load_finished, bus.line_count}
            !== {er, ed, es, eb, ef, ec}) begin
            nmis++;
            $display("FAIL %s t=%0d got rdy=%b dout=%h stb=%b busy=%b fin=%b cnt=%0d, want rdy=%b dout=%h stb=%b busy=%b fin=%b cnt=%0d",
                     name, t, bus.src_ready, bus.data_out, bus.data_strobe, bus.busy,
                     bus.load_finished, bus.line_count, er, ed, es, eb, ef, ec);
        end
    endtask

    // One full load of NL words starting with start at edge t=0.
    // sw/sl: source stall of sl cycles before word index sw; hsw: start pulse
    // while word hsw is held; aw: reset pulse two cycles into word aw.
    task automatic run_load(input string name, input logic [7:0] prev, input int sw, input int sl,
                            input int hsw, input int aw);
        int         abort_t, last_t, rec_t, kk, nxt, cnt, hits;
        logic       in_hold, done;
        logic [7:0] ed;
        for (int k = 0; k < NL; k++)
            tk[k] = PER * k + 1 + ((sw >= 0 && k >= sw) ? sl : 0);
        abort_t = (aw >= 0) ? tk[aw] + 2 : -1;
        last_t  = tk[NL-1] + HD + 3;
        rec_t   = last_t;
        for (int t = 0; t <= last_t; t++) begin
            @(negedge clk);
            rst_n         = (t == abort_t) ? 1'b0 : 1'b1;
            bus.start     = (t == 0) || (hsw >= 0 && t == tk[hsw] + 1);
            bus.src_valid = !(sw >= 0 && t >= tk[sw] - sl && t < tk[sw]);
            nxt = -1;
            for (int k = NL - 1; k >= 0; k--)
                if (tk[k] >= t) nxt = k;
            bus.src_data = (nxt >= 0) ? words[nxt] : 8'h00;
            @(posedge clk);
            #1;
            dec_hist[t] = dec;
            if (t == abort_t) begin
                check({name, " reset"}, t, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
                rec_t = t;
                break;
            end
            kk = -1;
            for (int k = 0; k < NL; k++)
                if (tk[k] <= t) kk = k;
            in_hold = (kk >= 0) && (t - tk[kk] < HD);
            cnt     = (kk < 0) ? 0 : (in_hold ? kk : kk + 1);
            done    = (cnt == NL);
            ed      = (kk < 0) ? prev : words[kk];
            check(name, t, !done && !in_hold, ed, (kk >= 0) && (t == tk[kk]),
                  !done, done, 8'(cnt));
        end
        if (aw >= 0) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                rst_n = 1'b1; bus.start = 1'b0; bus.src_valid = 1'b1; bus.src_data = 8'h77;
                @(posedge clk);
                #1;
                check({name, " idle"}, i, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
            end
        end
        // Each word must appear on the sampler output for at least two cycles
        for (int k = 0; k < NL; k++) begin
            if (tk[k] + HD + 3 <= rec_t) begin
                hits = 0;
                for (int t = tk[k] + 1; t <= tk[k] + HD + 3; t++)
                    if (dec_hist[t] == words[k]) hits++;
                nvec++;
                if (hits < 2) begin
                    nmis++;
                    $display("FAIL %s sampler word %0d got %0d cycles of %h, want >=2",
                             name, k, hits, words[k]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; bus.start = 1'b0; bus.src_valid = 1'b0; bus.src_data = 8'h00;

        //            rst start vld data   rdy dout   stb busy fin cnt
        vecs[0]  = mk(0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0, 8'd0);
        vecs[1]  = mk(1, 0, 1, 8'h55,  0, 8'h00, 0, 0, 0, 8'd0);
        vecs[2]  = mk(1, 1, 0, 8'h00,  1, 8'h00, 0, 1, 0, 8'd0);
        vecs[3]  = mk(1, 0, 0, 8'h00,  1, 8'h00, 0, 1, 0, 8'd0);
        vecs[4]  = mk(1, 0, 1, 8'h11,  0, 8'h11, 1, 1, 0, 8'd0);
        vecs[5]  = mk(1, 1, 1, 8'h22,  0, 8'h11, 0, 1, 0, 8'd0);
        vecs[6]  = mk(1, 0, 1, 8'h22,  0, 8'h11, 0, 1, 0, 8'd0);
        vecs[7]  = mk(1, 0, 1, 8'h22,  0, 8'h11, 0, 1, 0, 8'd0);
        vecs[8]  = mk(1, 0, 0, 8'h22,  1, 8'h11, 0, 1, 0, 8'd1);
        vecs[9]  = mk(1, 1, 1, 8'h11,  0, 8'h11, 1, 1, 0, 8'd1);
        vecs[10] = mk(1, 0, 1, 8'h00,  0, 8'h11, 0, 1, 0, 8'd1);
        vecs[11] = mk(1, 0, 0, 8'h00,  0, 8'h11, 0, 1, 0, 8'd1);
        vecs[12] = mk(1, 0, 0, 8'h00,  0, 8'h11, 0, 1, 0, 8'd1);
        vecs[13] = mk(1, 0, 0, 8'h00,  1, 8'h11, 0, 1, 0, 8'd2);
        vecs[14] = mk(1, 0, 1, 8'h33,  0, 8'h33, 1, 1, 0, 8'd2);
        vecs[15] = mk(1, 0, 1, 8'h33,  0, 8'h33, 0, 1, 0, 8'd2);
        vecs[16] = mk(0, 0, 1, 8'h33,  0, 8'h00, 0, 0, 0, 8'd0);
        vecs[17] = mk(1, 0, 1, 8'h44,  0, 8'h00, 0, 0, 0, 8'd0);
        vecs[18] = mk(1, 1, 1, 8'h44,  1, 8'h00, 0, 1, 0, 8'd0);
        vecs[19] = mk(0, 0, 1, 8'h44,  0, 8'h00, 0, 0, 0, 8'd0);
        vecs[20] = mk(1, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0, 8'd0);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            rst_n         = vecs[i].rst_n;
            bus.start     = vecs[i].start;
            bus.src_valid = vecs[i].valid;
            bus.src_data  = vecs[i].data;
            @(posedge clk);
            #1;
            check("vec", i, vecs[i].ready, vecs[i].dout, vecs[i].strobe,
                  vecs[i].busy, vecs[i].fin, vecs[i].count);
        end

        // Clean load 0x01..0xFF, source always valid
        for (int i = 0; i < NL; i++) words[i] = 8'(i + 1);
        run_load("run1", 8'h00, -1, 0, -1, -1);

        // Restart from DONE: stall after 0x03, three 0xAA words, start during HOLD
        for (int i = 0; i < NL; i++) words[i] = 8'(i + 1);
        words[10] = 8'hAA; words[11] = 8'hAA; words[12] = 8'hAA;
        run_load("run2", 8'hFF, 3, 10, 5, -1);

        // Restart again, reset pulse during word 100
        for (int i = 0; i < NL; i++) words[i] = 8'(i + 1);
        run_load("run3", 8'hFF, -1, 0, -1, 99);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/ir_loader_tx.md
IR_LOADER_TX -- requirements
Module: ir_loader_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of instruction bus words.
REQ-002 SHALL have parameter LINES, default 255: number of instruction words per load (1..255).
REQ-003 SHALL have parameter HOLD, default 4: cycles each word is driven on data_out (>=3, so a two-stage stability sampler sees it equal on two consecutive samples).
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have: start  in  1  begin a load sequence; sampled only in IDLE or DONE.
REQ-006 SHALL have: src_data  in  DATA_WIDTH  next instruction word from host/ROM; src_valid  in  1  src_data valid.
REQ-007 SHALL have: src_ready  out  1  block accepts src_data this cycle.
REQ-008 SHALL have: data_out  out  DATA_WIDTH  instruction bus toward decoder; data_strobe  out  1  one-cycle pulse on first cycle a new word is driven.
REQ-009 SHALL have: busy  out  1  sequence in progress; load_finished  out  1  all LINES words sent (level); line_count  out  8  words completed.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT_SRC, HOLD, DONE, all registered on posedge clk.
REQ-011 IDLE/DONE + start=1 SHALL go to WAIT_SRC next cycle, clear line_count to 0, clear load_finished; data_out unchanged.
REQ-012 start SHALL be ignored in WAIT_SRC and HOLD.
REQ-013 src_ready SHALL be 1 combinationally only in WAIT_SRC; transfer occurs when src_valid && src_ready.
REQ-014 On transfer, data_out SHALL take src_data next cycle, data_strobe SHALL be 1 for exactly that cycle, FSM SHALL enter HOLD with hold counter 0.
REQ-015 In HOLD, hold counter SHALL increment each cycle; data_out SHALL be constant for exactly HOLD cycles starting the cycle after transfer.
REQ-016 On last HOLD cycle (counter==HOLD-1), line_count SHALL increment by 1 next cycle; if new value==LINES go to DONE, else WAIT_SRC.
REQ-017 In WAIT_SRC with src_valid=0 (source stall), data_out SHALL hold the previous word, data_strobe=0, no timeout.
REQ-018 Back-to-back valid source SHALL yield one word per HOLD+1 cycles (1 WAIT_SRC + HOLD).
REQ-019 Identical consecutive words SHALL each still be held HOLD cycles and counted separately; data_strobe distinguishes them.
REQ-020 busy SHALL be 1 in WAIT_SRC and HOLD, 0 in IDLE and DONE.
REQ-021 load_finished SHALL be 1 in DONE and remain 1 until reset or a new start; data_out retains final word in DONE.
REQ-022 line_count SHALL never exceed LINES; no wrap-around.

Reset
REQ-023 rst_n=0 at a posedge SHALL force IDLE, data_out=0, data_strobe=0, src_ready=0, busy=0, load_finished=0, line_count=0, hold counter=0.
REQ-024 Reset mid-HOLD or mid-WAIT_SRC SHALL abort the sequence with no partial count retained; a new start is required.

Verification
REQ-025 Reset then start, src_valid always 1, words 0x01..0xFF -> each word on data_out exactly 4 cycles, strobe once per word, load_finished=1 after 255*5 cycles following start+1, line_count=255.
REQ-026 Source stall: src_valid low 10 cycles after word 3 (0x03) -> data_out stays 0x03, no strobe, busy=1, line_count=3 throughout; resumes correctly.
REQ-027 Repeated words 0xAA,0xAA,0xAA -> three strobes, line_count advances by 3, data_out constant 0xAA for 15 cycles.
REQ-028 start pulsed during HOLD -> no effect; in DONE -> line_count=0, load_finished=0 next cycle, new sequence runs.
REQ-029 rst_n low 1 cycle during word 100 -> all outputs at reset values next cycle; FSM idle until start.
REQ-030 Loopback with ir_decoder-style two-stage stability sampler -> sampler output equals each transmitted word for >=2 cycles per word.
